input_port_buffer: RTL and testbench
====================================

# input_port_buffer

Per-port ingress stage of the router, one instance per input port, directly upstream of the switch allocator and crossbar. Buffers incoming flits in a FIFO and computes the XY output port from each head flit, holding it for the packet. Raises a switch request to the allocator and pops the head flit on grant. Drives on/off backpressure to the upstream neighbour from FIFO occupancy thresholds.

## Interface
- BUFFER_DEPTH, 8: FIFO entries; power of 2, ≥4.
- COORD_W, 4: width of one mesh coordinate.
- PAYLOAD_W, 32: flit payload width; must be ≥ 2*COORD_W.
- X_CUR, 0: this router's X coordinate.
- Y_CUR, 0: this router's Y coordinate.
- OFF_THRESH, BUFFER_DEPTH-2: occupancy at or above which on_off_o drops.
- ON_THRESH, BUFFER_DEPTH-4: occupancy at or below which on_off_o rises; must be < OFF_THRESH.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flit_i  in  2+PAYLOAD_W  {type[1:0], payload}; type HEAD=00, BODY=01, TAIL=10, HEADTAIL=11.
- valid_i  in  1  flit_i valid; push this cycle.
- on_off_o  out  1  1 = upstream may send; registered.
- switch_request_o  out  1  head flit ready for allocation; maps to switch_request[port].
- out_port_o  out  PORT_SIZE  requested output port; maps to out_port[port].
- valid_sel_i  in  1  grant from switch allocator (valid_sel[port]); pops head this cycle.
- flit_o  out  2+PAYLOAD_W  FIFO head flit, to crossbar.
- overflow_o  out  1  sticky: push while full.
- proto_err_o  out  1  sticky: BODY/TAIL at head while IDLE.

## Operation
- Ports: LOCAL=0, NORTH=1, SOUTH=2, WEST=3, EAST=4 (PORT_NUM=5).
- Head destination: dest_x = payload[2*COORD_W-1:COORD_W], dest_y = payload[COORD_W-1:0].
- XY routing, unsigned compares:
  - dest_x>X_CUR gives EAST; dest_x<X_CUR gives WEST.
  - Otherwise dest_y>Y_CUR gives NORTH; dest_y<Y_CUR gives SOUTH.
  - Otherwise LOCAL.
- FIFO: circular buffer, read/write pointers of log2(BUFFER_DEPTH) bits, wrap naturally. Count is log2(BUFFER_DEPTH)+1 bits. flit_o = mem[rd_ptr] combinationally.
- Push when valid_i and not full. Push when full: flit dropped, overflow_o set.
- Push and pop in the same cycle: both take effect, count unchanged. When full, pop frees the slot and the push is accepted.
- State machine IDLE / ACTIVE:
  - IDLE with FIFO empty: switch_request_o=0.
  - IDLE with HEAD or HEADTAIL at the FIFO head: switch_request_o=1, out_port_o=XY(head), combinational.
    - Grant on HEAD: latch the port into route_q, go to ACTIVE.
    - Grant on HEADTAIL: stay in IDLE.
  - IDLE with BODY or TAIL at the FIFO head: the flit is popped and discarded autonomously, proto_err_o is set, no request is made.
  - ACTIVE: switch_request_o = !empty; out_port_o = route_q.
    - Grant on TAIL: go to IDLE.
    - Grant on BODY: stay in ACTIVE.
    - A HEAD arriving in ACTIVE is forwarded as a body flit; no error is flagged.
- valid_sel_i while switch_request_o=0 is ignored; no pop.
- on_off_o is computed from next-cycle occupancy:
  - Cleared when count_next ≥ OFF_THRESH.
  - Set when count_next ≤ ON_THRESH.
  - Otherwise held (hysteresis).
- Reset (async, rst=0):
  - Pointers and count = 0, state = IDLE, route_q = LOCAL.
  - on_off_o=1, overflow_o=0, proto_err_o=0.
  - switch_request_o=0; out_port_o=0; flit_o = don't-care.
- Reset mid-packet discards all buffered flits and the packet context.

## Timing
- Push at edge n: the flit can be at the FIFO head, and switch_request_o can rise, in cycle n+1. Zero-bypass; minimum ingress-to-request latency is 1 cycle.
- Grant in cycle m: flit_o is valid during m and crosses the crossbar in the same cycle. rd_ptr advances at edge m, and the next flit is requestable in m+1.
- Back-to-back grants give 1 flit/cycle.
- on_off_o is registered: it reflects occupancy after edge n during cycle n+1. Upstream round-trip slack is BUFFER_DEPTH-OFF_THRESH entries.
- Sticky flags are set at the edge following the event and clear only on reset.

## Test plan
- Reset: hold rst=0 mid-stream → on_off_o=1, switch_request_o=0, overflow_o=0, proto_err_o=0. After release, the first pushed HEAD to (0,0) at X_CUR=Y_CUR=0 requests out_port_o=0 one cycle later.
- Routing, X_CUR=Y_CUR=2, single HEADTAIL flits:
  - dest (3,1) → EAST (4).
  - dest (1,5) → WEST (3).
  - dest (2,5) → NORTH (1).
  - dest (2,0) → SOUTH (2).
  - dest (2,2) → LOCAL (0).
- Packet hold: HEAD (3,2), BODY, BODY, TAIL, granted each cycle → out_port_o=4 on all four, state returns to IDLE after TAIL. A following HEADTAIL (1,2) requests port 3.
- Full/flow control, DEPTH=8, no grants:
  - 6 pushes: on_off_o=0 from the cycle after the 6th.
  - 2 more pushes fill the FIFO; a 9th push sets overflow_o and the flit is dropped.
  - Grants down to count 4: on_off_o=1.
- Simultaneous push and pop while full: count stays 8, no overflow, flit order is preserved on readout.
- Protocol error: push BODY into an empty FIFO in IDLE → proto_err_o=1, the flit is discarded with no request, and a subsequent HEAD is processed normally.

Source files
------------

// File: rtl/input_port_buffer_if.sv
// Ingress-side bundle of one router input port: upstream flit link plus the
// switch-allocator request/grant pair and the crossbar-facing head flit.
interface input_port_buffer_if #(
  parameter int PAYLOAD_W = 32,
  parameter int PORT_SIZE = 3
);
  // Handshake: a flit moves upstream->buffer on every cycle with valid_i=1 (no
  // ready; flow control is the registered on_off_o level), and buffer->crossbar
  // on every cycle where switch_request_o and valid_sel_i are both 1.
  logic [PAYLOAD_W+1:0] flit_i;
  logic                 valid_i;
  logic                 on_off_o;
  logic                 switch_request_o;
  logic [PORT_SIZE-1:0] out_port_o;
  logic                 valid_sel_i;
  logic [PAYLOAD_W+1:0] flit_o;

  modport slave (
    input  flit_i, valid_i, valid_sel_i,
    output on_off_o, switch_request_o, out_port_o, flit_o
  );

  modport master (
    output flit_i, valid_i, valid_sel_i,
    input  on_off_o, switch_request_o, out_port_o, flit_o
  );
endinterface

// File: rtl/input_port_buffer.sv
// Router input port: flit FIFO, XY route computation on head flits with a
// per-packet route hold, switch request/grant, and on/off backpressure.
module input_port_buffer #(
  parameter int BUFFER_DEPTH = 8,
  parameter int COORD_W      = 4,
  parameter int PAYLOAD_W    = 32,
  parameter int X_CUR        = 0,
  parameter int Y_CUR        = 0,
  parameter int OFF_THRESH   = BUFFER_DEPTH - 2,
  parameter int ON_THRESH    = BUFFER_DEPTH - 4
) (
  input  logic                clk,
  input  logic                rst,
  input_port_buffer_if.slave  bus,
  output logic                overflow_o,
  output logic                proto_err_o,
  output logic                state_o
);
  localparam int FLIT_W    = PAYLOAD_W + 2;
  localparam int PTR_W     = $clog2(BUFFER_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int PORT_SIZE = 3;

  localparam logic [PORT_SIZE-1:0] PORT_LOCAL = 3'd0;
  localparam logic [PORT_SIZE-1:0] PORT_NORTH = 3'd1;
  localparam logic [PORT_SIZE-1:0] PORT_SOUTH = 3'd2;
  localparam logic [PORT_SIZE-1:0] PORT_WEST  = 3'd3;
  localparam logic [PORT_SIZE-1:0] PORT_EAST  = 3'd4;

  localparam logic [1:0] T_HEAD     = 2'b00;
  localparam logic [1:0] T_HEADTAIL = 2'b11;

  localparam logic [COORD_W-1:0] X_CUR_C = COORD_W'(X_CUR);
  localparam logic [COORD_W-1:0] Y_CUR_C = COORD_W'(Y_CUR);
  localparam logic [CNT_W-1:0]   FULL_C  = CNT_W'(BUFFER_DEPTH);
  localparam logic [CNT_W-1:0]   OFF_C   = CNT_W'(OFF_THRESH);
  localparam logic [CNT_W-1:0]   ON_C    = CNT_W'(ON_THRESH);

  typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [PORT_SIZE-1:0]  route_q, route_d;
  logic [FLIT_W-1:0]     mem_q [BUFFER_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  on_off_q, on_off_d;
  logic                  overflow_q, proto_err_q;

  logic                  empty, full;
  logic [FLIT_W-1:0]     head;
  logic [1:0]            head_type;
  logic [COORD_W-1:0]    head_x, head_y;
  logic [PORT_SIZE-1:0]  xy_port;
  logic                  sreq, discard, grant, push, pop, overflow_evt;
  logic [PORT_SIZE-1:0]  out_port;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_C);
  assign head      = mem_q[rd_ptr_q];
  assign head_type = head[FLIT_W-1 -: 2];
  assign head_x    = head[2*COORD_W-1 : COORD_W];
  assign head_y    = head[COORD_W-1:0];

  // Dimension-ordered routing: resolve X completely before Y.
  always_comb begin
    xy_port = PORT_LOCAL;
    if (head_x > X_CUR_C)      xy_port = PORT_EAST;
    else if (head_x < X_CUR_C) xy_port = PORT_WEST;
    else if (head_y > Y_CUR_C) xy_port = PORT_NORTH;
    else if (head_y < Y_CUR_C) xy_port = PORT_SOUTH;
  end

  // FSM output process: request, requested port and orphan-flit discard.
  always_comb begin
    sreq     = 1'b0;
    out_port = PORT_LOCAL;
    discard  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          if (head_type == T_HEAD || head_type == T_HEADTAIL) begin
            sreq     = 1'b1;
            out_port = xy_port;
          end else begin
            discard = 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        sreq     = !empty;
        out_port = route_q;
      end
      default: ;
    endcase
  end

  assign grant        = bus.valid_sel_i && sreq;
  assign pop          = grant || discard;
  assign push         = bus.valid_i && (!full || pop);
  assign overflow_evt = bus.valid_i && full && !pop;

  // FSM next-state process. Any granted flit with the tail bit set (TAIL or
  // HEADTAIL) closes an open packet; a HEAD seen mid-packet is just payload.
  always_comb begin
    state_d = state_q;
    route_d = route_q;
    case (state_q)
      S_IDLE: begin
        if (grant && head_type == T_HEAD) begin
          state_d = S_ACTIVE;
          route_d = xy_port;
        end
      end
      S_ACTIVE: begin
        if (grant && head_type[1]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      route_q <= PORT_LOCAL;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  // Hysteresis band between ON and OFF thresholds keeps the last decision.
  always_comb begin
    on_off_d = on_off_q;
    if (count_d >= OFF_C)     on_off_d = 1'b0;
    else if (count_d <= ON_C) on_off_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      on_off_q    <= 1'b1;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q  <= count_d;
      on_off_q <= on_off_d;
      if (overflow_evt) overflow_q  <= 1'b1;
      if (discard)      proto_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.flit_i;
  end

  assign bus.on_off_o         = on_off_q;
  assign bus.switch_request_o = sreq;
  assign bus.out_port_o       = out_port;
  assign bus.flit_o           = head;
  assign overflow_o           = overflow_q;
  assign proto_err_o          = proto_err_q;
  assign state_o              = (state_q == S_ACTIVE);

endmodule

// File: tb/tb_input_port_buffer.sv
// Directed bench for input_port_buffer at router (2,2): routing, packet hold,
// backpressure thresholds, overflow, full push/pop, protocol error and reset.
module tb_input_port_buffer;
  localparam int PAYLOAD_W = 32;
  localparam int FLIT_W    = PAYLOAD_W + 2;
  localparam int W         = 3 + FLIT_W;

  localparam logic [1:0] T_HEAD     = 2'b00;
  localparam logic [1:0] T_BODY     = 2'b01;
  localparam logic [1:0] T_TAIL     = 2'b10;
  localparam logic [1:0] T_HEADTAIL = 2'b11;

  logic clk = 1'b0;
  logic rst;
  logic overflow, proto_err, state;

  int n_vec = 0;
  int n_err = 0;
  int tag   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  input_port_buffer_if #(.PAYLOAD_W(PAYLOAD_W), .PORT_SIZE(3)) bus ();

  input_port_buffer #(
    .BUFFER_DEPTH(8), .COORD_W(4), .PAYLOAD_W(PAYLOAD_W),
    .X_CUR(2), .Y_CUR(2), .OFF_THRESH(6), .ON_THRESH(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .overflow_o(overflow), .proto_err_o(proto_err), .state_o(state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_flit(input logic [1:0] t, input logic [3:0] x, input logic [3:0] y,
                           input logic [2:0] port, input bit keep);
    logic [FLIT_W-1:0] f;
    tag++;
    f = {t, 8'(tag), 16'hC0DE, x, y};
    bus.flit_i  = f;
    bus.valid_i = 1'b1;
    if (keep) exp_q.push_back({port, f});
    tick();
    bus.valid_i = 1'b0;
  endtask

  task automatic grant_once();
    bus.valid_sel_i = 1'b1;
    tick();
    bus.valid_sel_i = 1'b0;
  endtask

  task automatic push_grant(input logic [1:0] t, input logic [3:0] x, input logic [3:0] y,
                            input logic [2:0] port);
    bus.valid_sel_i = 1'b1;
    push_flit(t, x, y, port, 1'b1);
    bus.valid_sel_i = 1'b0;
  endtask

  // Scoreboard monitor: every granted flit must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && bus.valid_sel_i && bus.switch_request_o) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL grant: unexpected flit port %0d flit %0h", bus.out_port_o, bus.flit_o);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.out_port_o, bus.flit_o} !== mon_e) begin
          n_err++;
          $display("FAIL grant: got port %0d flit %0h expected port %0d flit %0h",
                   bus.out_port_o, bus.flit_o, mon_e[W-1 -: 3], mon_e[FLIT_W-1:0]);
        end
      end
    end
  end

  logic [3:0] rx [5] = '{4'd3, 4'd1, 4'd2, 4'd2, 4'd2};
  logic [3:0] ry [5] = '{4'd1, 4'd5, 4'd5, 4'd0, 4'd2};
  logic [2:0] rp [5] = '{3'd4, 3'd3, 3'd1, 3'd2, 3'd0};

  initial begin
    rst             = 1'b0;
    bus.flit_i      = '0;
    bus.valid_i     = 1'b0;
    bus.valid_sel_i = 1'b0;
    repeat (3) tick();
    check("rst on_off", 64'(bus.on_off_o), 64'd1);
    check("rst sreq", 64'(bus.switch_request_o), 64'd0);
    check("rst overflow", 64'(overflow), 64'd0);
    check("rst proto_err", 64'(proto_err), 64'd0);
    check("rst out_port", 64'(bus.out_port_o), 64'd0);
    rst = 1'b1;
    tick();

    // First head after reset requests one cycle after its push.
    push_flit(T_HEADTAIL, 4'd2, 4'd2, 3'd0, 1'b1);
    check("first sreq", 64'(bus.switch_request_o), 64'd1);
    check("first port", 64'(bus.out_port_o), 64'd0);
    grant_once();
    check("first drained sreq", 64'(bus.switch_request_o), 64'd0);

    for (int i = 0; i < 5; i++) begin
      push_flit(T_HEADTAIL, rx[i], ry[i], rp[i], 1'b1);
      check($sformatf("route%0d port", i), 64'(bus.out_port_o), 64'(rp[i]));
      grant_once();
    end

    // Packet hold: route computed from the head applies to all four flits.
    push_flit(T_HEAD, 4'd3, 4'd2, 3'd4, 1'b1);
    push_flit(T_BODY, 4'd0, 4'd0, 3'd4, 1'b1);
    push_flit(T_BODY, 4'd15, 4'd15, 3'd4, 1'b1);
    push_flit(T_TAIL, 4'd1, 4'd1, 3'd4, 1'b1);
    grant_once();
    check("pkt active", 64'(state), 64'd1);
    repeat (3) grant_once();
    check("pkt idle", 64'(state), 64'd0);
    check("pkt drained sreq", 64'(bus.switch_request_o), 64'd0);
    push_flit(T_HEADTAIL, 4'd1, 4'd2, 3'd3, 1'b1);
    check("post pkt port", 64'(bus.out_port_o), 64'd3);
    grant_once();

    // Fill without grants: thresholds, then overflow on the 9th push.
    for (int i = 1; i <= 8; i++) begin
      push_flit(T_HEADTAIL, 4'd2, 4'd2, 3'd0, 1'b1);
      if (i == 5) check("on_off at 5", 64'(bus.on_off_o), 64'd1);
      if (i == 6) check("on_off at 6", 64'(bus.on_off_o), 64'd0);
    end
    check("full no overflow", 64'(overflow), 64'd0);
    push_flit(T_HEADTAIL, 4'd3, 4'd3, 3'd4, 1'b0);
    check("overflow set", 64'(overflow), 64'd1);
    check("on_off full", 64'(bus.on_off_o), 64'd0);
    repeat (3) grant_once();
    check("on_off at 5 hyst", 64'(bus.on_off_o), 64'd0);
    grant_once();
    check("on_off at 4", 64'(bus.on_off_o), 64'd1);
    push_flit(T_HEADTAIL, 4'd2, 4'd2, 3'd0, 1'b1);
    push_flit(T_HEADTAIL, 4'd2, 4'd2, 3'd0, 1'b1);
    check("on_off refill 6", 64'(bus.on_off_o), 64'd0);

    // Reset mid-stream discards buffered flits and clears sticky flags.
    rst = 1'b0;
    #2;
    check("mid rst on_off", 64'(bus.on_off_o), 64'd1);
    check("mid rst sreq", 64'(bus.switch_request_o), 64'd0);
    check("mid rst overflow", 64'(overflow), 64'd0);
    check("mid rst proto_err", 64'(proto_err), 64'd0);
    exp_q.delete();
    tick();
    rst = 1'b1;
    tick();
    check("post rst idle", 64'(state), 64'd0);
    check("post rst sreq", 64'(bus.switch_request_o), 64'd0);

    // Full FIFO with simultaneous push and pop: accepted, order kept.
    for (int i = 0; i < 8; i++) push_flit(T_HEADTAIL, 4'd3, 4'd2, 3'd4, 1'b1);
    check("full on_off", 64'(bus.on_off_o), 64'd0);
    push_grant(T_HEADTAIL, 4'd1, 4'd2, 3'd3);
    push_grant(T_HEADTAIL, 4'd1, 4'd2, 3'd3);
    check("pushpop overflow", 64'(overflow), 64'd0);
    repeat (7) grant_once();
    check("one left sreq", 64'(bus.switch_request_o), 64'd1);
    grant_once();
    check("empty sreq", 64'(bus.switch_request_o), 64'd0);

    // Orphan BODY in IDLE is discarded without a request.
    push_flit(T_BODY, 4'd3, 4'd3, 3'd4, 1'b0);
    check("orphan sreq", 64'(bus.switch_request_o), 64'd0);
    check("orphan pe pre", 64'(proto_err), 64'd0);
    tick();
    check("orphan pe set", 64'(proto_err), 64'd1);
    check("orphan gone sreq", 64'(bus.switch_request_o), 64'd0);
    push_flit(T_HEADTAIL, 4'd2, 4'd5, 3'd1, 1'b1);
    check("after orphan sreq", 64'(bus.switch_request_o), 64'd1);
    check("after orphan port", 64'(bus.out_port_o), 64'd1);
    grant_once();
    check("pe sticky", 64'(proto_err), 64'd1);

    tick();
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
